bit_analyzer: RTL and testbench

- Parametrised successor to the single-mode ones-counter datapath. Loads a W-bit word into a shift register and runs one of four serial analyses, one bit per clock.
- Modes: count ones, count zeros, leading-one index, trailing-one index.
- Used behind switch/key inputs on the DE1-SoC top level. The result drives a HEX digit and Done drives an LED.

---
 rtl/bit_analyzer_if.sv | 32 +++
 rtl/bit_analyzer.sv | 132 +++++++++++++
 tb/tb_bit_analyzer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bit_analyzer_if.sv
// ============================================================================
// Module   : bit_analyzer_if
// Brief    : Load/start/result bundle between a controller and bit_analyzer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface bit_analyzer_if #(
    parameter int W  = 8,
    parameter int CW = 4
);
    logic          LA;
    logic          s;
    logic [1:0]    mode;
    logic [W-1:0]  data;
    logic [CW-1:0] result;
    logic          found;
    logic          busy;
    logic          Done;

    modport master (
        output LA, s, mode, data,
        input  result, found, busy, Done
    );

    modport slave (
        input  LA, s, mode, data,
        output result, found, busy, Done
    );
endinterface

`default_nettype wire

// File: rtl/bit_analyzer.sv
// ============================================================================
// Module   : bit_analyzer
// Brief    : Serial W-bit analyser: ones/zeros count, leading/trailing one index.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bit_analyzer #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    bit_analyzer_if.slave bus
);
    localparam int IW = $clog2(W + 1);

    localparam logic [1:0] MODE_ONES  = 2'd0;
    localparam logic [1:0] MODE_ZEROS = 2'd1;
    localparam logic [1:0] MODE_LEAD  = 2'd2;
    localparam logic [1:0] MODE_TRAIL = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state,  state_n;
    logic [W-1:0]  a,      a_n;
    logic [IW-1:0] idx,    idx_n;
    logic [1:0]    mode_r, mode_n;
    logic [CW-1:0] result, result_n;
    logic          found,  found_n;

    logic          exit_now;
    logic [CW-1:0] bit_one;
    logic [CW-1:0] bit_zero;
    logic [CW-1:0] idx_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a      <= '0;
            idx    <= '0;
            mode_r <= MODE_ONES;
            result <= '0;
            found  <= 1'b0;
        end else begin
            state  <= state_n;
            a      <= a_n;
            idx    <= idx_n;
            mode_r <= mode_n;
            result <= result_n;
            found  <= found_n;
        end
    end

    assign bit_one  = {{(CW-1){1'b0}},  a[0]};
    assign bit_zero = {{(CW-1){1'b0}}, ~a[0]};
    assign idx_ext  = {{(CW-IW){1'b0}}, idx};

    // ZEROS must visit every position; the other modes stop once A runs dry.
    assign exit_now = (mode_r == MODE_ZEROS) ? (idx == IW'(W)) : (a == '0);

    always_comb begin
        state_n  = state;
        a_n      = a;
        idx_n    = idx;
        mode_n   = mode_r;
        result_n = result;
        found_n  = found;

        case (state)
            IDLE: begin
                if (bus.LA) begin
                    a_n = bus.data;
                end else if (bus.s) begin
                    mode_n   = bus.mode;
                    result_n = '0;
                    found_n  = 1'b0;
                    idx_n    = '0;
                    state_n  = COUNT;
                end
            end

            COUNT: begin
                if (exit_now) begin
                    state_n = DONE;
                end else begin
                    a_n   = a >> 1;
                    idx_n = idx + IW'(1);
                    case (mode_r)
                        MODE_ONES:  result_n = result + bit_one;
                        MODE_ZEROS: result_n = result + bit_zero;
                        MODE_LEAD: begin
                            if (a[0]) begin
                                result_n = idx_ext;
                                found_n  = 1'b1;
                            end
                        end
                        MODE_TRAIL: begin
                            // First 1 seen is the answer; stop right here.
                            if (a[0]) begin
                                result_n = idx_ext;
                                found_n  = 1'b1;
                                state_n  = DONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            DONE: begin
                if (!bus.s) begin
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign bus.result = result;
    assign bus.found  = found;
    assign bus.busy   = (state == COUNT);
    assign bus.Done   = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_bit_analyzer.sv
// ============================================================================
// Module   : tb_bit_analyzer
// Brief    : Directed + randomized bench for bit_analyzer at W=8 and W=16.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bit_analyzer;
    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    bit_analyzer_if #(.W(8),  .CW(4)) bus8  ();
    bit_analyzer_if #(.W(16), .CW(5)) bus16 ();

    bit_analyzer #(.W(8),  .CW(4)) dut8  (.clk(clk), .reset(reset), .bus(bus8));
    bit_analyzer #(.W(16), .CW(5)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic la, input logic st,
                         input logic [1:0] m, input logic [31:0] d);
        if (w == 8) begin
            bus8.LA = la; bus8.s = st; bus8.mode = m; bus8.data = d[7:0];
        end else begin
            bus16.LA = la; bus16.s = st; bus16.mode = m; bus16.data = d[15:0];
        end
    endtask

    task automatic sample(input int w, output logic bsy, output logic dn,
                          output logic [31:0] res, output logic fnd);
        if (w == 8) begin
            bsy = bus8.busy;  dn = bus8.Done;  res = 32'(bus8.result);  fnd = bus8.found;
        end else begin
            bsy = bus16.busy; dn = bus16.Done; res = 32'(bus16.result); fnd = bus16.found;
        end
    endtask

    // Reference: answer and COUNT-cycle count straight from the word's bit statistics.
    function automatic void model(input int w, input logic [1:0] m, input logic [31:0] word,
                                  output int res, output int fnd, output int cyc);
        int ones = 0;
        int hi   = -1;
        int lo   = -1;
        for (int i = 0; i < w; i++) begin
            if (word[i]) begin
                ones++;
                hi = i;
                if (lo < 0) lo = i;
            end
        end
        fnd = 0;
        case (m)
            2'd0: begin res = ones;     cyc = (hi < 0) ? 1 : hi + 2; end
            2'd1: begin res = w - ones; cyc = w + 1; end
            2'd2: begin
                res = (hi < 0) ? 0 : hi; fnd = (hi >= 0) ? 1 : 0;
                cyc = (hi < 0) ? 1 : hi + 2;
            end
            default: begin
                res = (lo < 0) ? 0 : lo; fnd = (lo >= 0) ? 1 : 0;
                cyc = (lo < 0) ? 1 : lo + 1;
            end
        endcase
    endfunction

    task automatic load(input int w, input logic [31:0] word);
        drive(w, 1'b1, 1'b0, 2'd0, word);
        tick();
        drive(w, 1'b0, 1'b0, 2'd0, word);
    endtask

    task automatic run(input int w, input logic [1:0] m, input logic [31:0] word,
                       input bit noise, input int hold);
        int res, fnd, cyc, seen;
        logic bsy, dn, f;
        logic [31:0] r;
        model(w, m, word, res, fnd, cyc);
        drive(w, 1'b0, 1'b1, m, 32'd0);
        tick();
        seen = 0;
        sample(w, bsy, dn, r, f);
        while (bsy && seen < 200) begin
            seen++;
            if (noise) drive(w, 1'b1, 1'b1, 2'($urandom), $urandom);
            tick();
            sample(w, bsy, dn, r, f);
        end
        drive(w, 1'b0, 1'b1, m, 32'd0);
        chk("count_cycles", 32'(seen), 32'(cyc));
        chk("done_high",    32'(dn),   32'd1);
        chk("result",       r,         32'(res));
        chk("found",        32'(f),    32'(fnd));
        for (int i = 0; i < hold; i++) begin
            tick();
            sample(w, bsy, dn, r, f);
            chk("hold_done",   32'({bsy, dn}), 32'b01);
            chk("hold_result", r,              32'(res));
        end
        drive(w, 1'b0, 1'b0, m, 32'd0);
        tick();
        sample(w, bsy, dn, r, f);
        chk("done_cleared", 32'({bsy, dn}), 32'b00);
        chk("result_kept",  r,              32'(res));
        chk("found_kept",   32'(f),         32'(fnd));
    endtask

    initial begin
        logic bsy, dn, f;
        logic [31:0] r;
        logic [31:0] word;
        logic [1:0]  m;

        drive(8,  1'b0, 1'b0, 2'd0, 32'd0);
        drive(16, 1'b0, 1'b0, 2'd0, 32'd0);
        reset = 1'b1;
        tick(); tick();
        sample(8, bsy, dn, r, f);
        chk("reset_8",  {28'd0, bsy, dn, f, 1'b0} | r, 32'd0);
        sample(16, bsy, dn, r, f);
        chk("reset_16", {28'd0, bsy, dn, f, 1'b0} | r, 32'd0);
        reset = 1'b0;
        tick();

        // Main word in every mode.
        for (int k = 0; k < 4; k++) begin
            load(8, 32'hAE);
            run(8, 2'(k), 32'hAE, 1'b0, 0);
        end
        // All-zero word in every mode.
        for (int k = 0; k < 4; k++) begin
            load(8, 32'h00);
            run(8, 2'(k), 32'h00, 1'b0, 0);
        end

        // Load with s in the same cycle must not start.
        drive(8, 1'b1, 1'b1, 2'd0, 32'h81);
        tick();
        sample(8, bsy, dn, r, f);
        chk("la_and_s_no_start", 32'({bsy, dn}), 32'b00);
        drive(8, 1'b0, 1'b0, 2'd0, 32'h0);
        tick();
        run(8, 2'd0, 32'h81, 1'b0, 0);

        // Reset three cycles into a ZEROS run.
        load(8, 32'hAE);
        drive(8, 1'b0, 1'b1, 2'd1, 32'd0);
        tick(); tick(); tick();
        reset = 1'b1;
        drive(8, 1'b0, 1'b0, 2'd1, 32'd0);
        tick();
        sample(8, bsy, dn, r, f);
        chk("midrun_reset_flags",  32'({bsy, dn, f}), 32'b000);
        chk("midrun_reset_result", r,                 32'd0);
        reset = 1'b0;
        tick();
        run(8, 2'd1, 32'h00, 1'b0, 0);

        // Hold s through DONE, with load noise during COUNT.
        load(8, 32'hAE);
        run(8, 2'd0, 32'hAE, 1'b1, 20);

        for (int n = 0; n < 30; n++) begin
            word = 32'($urandom_range(0, 255));
            m    = 2'($urandom);
            load(8, word);
            run(8, m, word, n[0], 0);
        end

        for (int k = 0; k < 4; k++) begin
            load(16, 32'h8001);
            run(16, 2'(k), 32'h8001, 1'b0, 0);
        end
        for (int n = 0; n < 12; n++) begin
            word = 32'($urandom_range(0, 65535));
            m    = 2'($urandom);
            load(16, word);
            run(16, m, word, n[0], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
